idle_power_ctrl: RTL and testbench

IDLE_POWER_CTRL -- requirements
Module: idle_power_ctrl

---
 rtl/idle_power_ctrl.sv | 161 ++++++++++++++++
 tb/tb_idle_power_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/idle_power_ctrl.sv
// Per-peripheral idle power controller: one sleep/wake handshake FSM per peripheral.
// Optional per-peripheral sleep-entry statistics are built when IDLE_PWR_STATS_EN is defined.
module idle_power_ctrl #(
    parameter int N           = 4,
    parameter int W           = 16,
    parameter int ACK_TIMEOUT = 16,
    parameter int WAKE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   idle_count,
    input  logic [N-1:0]     recent_activity,
    input  logic [N-1:0]     periph_en,
    input  logic [W-1:0]     idle_threshold,
    input  logic [N-1:0]     sleep_ack,
    input  logic [N-1:0]     wake_req,
    output logic [N-1:0]     sleep_req,
    output logic [N-1:0]     clk_gate,
    output logic [N*2-1:0]   pwr_state,
    output logic [N-1:0]     ack_timeout_err,
    output logic [N*8-1:0]   sleep_count
);

    typedef enum logic [1:0] {
        ST_ACTIVE    = 2'd0,
        ST_REQ_SLEEP = 2'd1,
        ST_SLEEP     = 2'd2,
        ST_WAKING    = 2'd3
    } pwr_state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] WAKE_LAST    = 8'(WAKE_CYCLES - 1);

    for (genvar i = 0; i < N; i++) begin : g_periph
        pwr_state_e state_q, state_d;
        logic [7:0] cnt_q, cnt_d;
        logic       err_q, err_d;
        logic       sleep_req_q, sleep_req_d;
        logic       clk_gate_q, clk_gate_d;
        logic       sleep_ok_s;
        logic       wake_ev_s;
        logic       enter_sleep_s;

        assign sleep_ok_s = (idle_threshold != {W{1'b0}})
                          && (idle_count[i*W +: W] >= idle_threshold)
                          && !recent_activity[i] && !wake_req[i];
        assign wake_ev_s  = wake_req[i] || recent_activity[i];

        // Next-state logic; cnt is shared between ack timeout and wake duration and cleared on each entry.
        always_comb begin
            state_d       = state_q;
            cnt_d         = cnt_q;
            err_d         = 1'b0;
            enter_sleep_s = 1'b0;
            if (!periph_en[i]) begin
                state_d = ST_ACTIVE;
                cnt_d   = 8'd0;
            end else begin
                case (state_q)
                    ST_ACTIVE: begin
                        if (sleep_ok_s) begin
                            state_d = ST_REQ_SLEEP;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = 8'd0;
                        end
                    end
                    ST_REQ_SLEEP: begin
                        if (sleep_ack[i]) begin
                            state_d       = ST_SLEEP;
                            cnt_d         = 8'd0;
                            enter_sleep_s = 1'b1;
                        end else if (wake_ev_s) begin
                            state_d = ST_ACTIVE;
                            cnt_d   = 8'd0;
                        end else if (cnt_q == TIMEOUT_LAST) begin
                            state_d = ST_ACTIVE;
                            cnt_d   = 8'd0;
                            err_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    ST_SLEEP: begin
                        if (wake_ev_s) begin
                            state_d = ST_WAKING;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = 8'd0;
                        end
                    end
                    ST_WAKING: begin
                        if (cnt_q == WAKE_LAST) begin
                            state_d = ST_ACTIVE;
                            cnt_d   = 8'd0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_d = ST_ACTIVE;
                        cnt_d   = 8'd0;
                    end
                endcase
            end
            sleep_req_d = (state_d == ST_REQ_SLEEP);
            clk_gate_d  = (state_d == ST_SLEEP);
        end

        // State, counter and registered output flops.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q     <= ST_ACTIVE;
                cnt_q       <= 8'd0;
                err_q       <= 1'b0;
                sleep_req_q <= 1'b0;
                clk_gate_q  <= 1'b0;
            end else begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                err_q       <= err_d;
                sleep_req_q <= sleep_req_d;
                clk_gate_q  <= clk_gate_d;
            end
        end

        assign sleep_req[i]         = sleep_req_q;
        assign clk_gate[i]          = clk_gate_q;
        assign ack_timeout_err[i]   = err_q;
        assign pwr_state[i*2 +: 2]  = state_q;

`ifdef IDLE_PWR_STATS_EN
        logic [7:0] scnt_q, scnt_d;

        // Saturating count of sleep entries.
        always_comb begin
            if (enter_sleep_s && (scnt_q != 8'hFF)) begin
                scnt_d = scnt_q + 8'd1;
            end else begin
                scnt_d = scnt_q;
            end
        end

        // Statistics flop, cleared only by reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                scnt_q <= 8'd0;
            end else begin
                scnt_q <= scnt_d;
            end
        end

        assign sleep_count[i*8 +: 8] = scnt_q;
`else
        logic unused_enter_s;
        assign unused_enter_s        = enter_sleep_s;
        assign sleep_count[i*8 +: 8] = 8'd0;
`endif
    end

endmodule

// File: tb/tb_idle_power_ctrl.sv
// Directed self-checking bench for idle_power_ctrl (N=4, W=16, ACK_TIMEOUT=16, WAKE_CYCLES=4).
module tb_idle_power_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] idle_count;
    logic [3:0]  recent_activity;
    logic [3:0]  periph_en;
    logic [15:0] idle_threshold;
    logic [3:0]  sleep_ack;
    logic [3:0]  wake_req;
    logic [3:0]  sleep_req;
    logic [3:0]  clk_gate;
    logic [7:0]  pwr_state;
    logic [3:0]  ack_timeout_err;
    logic [31:0] sleep_count;

    int n_vec = 0;
    int n_err = 0;

    idle_power_ctrl #(.N(4), .W(16), .ACK_TIMEOUT(16), .WAKE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .idle_count(idle_count), .recent_activity(recent_activity),
        .periph_en(periph_en), .idle_threshold(idle_threshold), .sleep_ack(sleep_ack),
        .wake_req(wake_req), .sleep_req(sleep_req), .clk_gate(clk_gate),
        .pwr_state(pwr_state), .ack_timeout_err(ack_timeout_err), .sleep_count(sleep_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_count = 64'd0; recent_activity = 4'd0; periph_en = 4'd0;
        idle_threshold = 16'd0; sleep_ack = 4'd0; wake_req = 4'd0;
        step(); step();
        n_vec++;
        if ({sleep_req, clk_gate, pwr_state, ack_timeout_err, sleep_count} !== 52'd0) begin
            n_err++; $display("FAIL reset_outputs got=%h exp=0", {sleep_req, clk_gate, pwr_state, ack_timeout_err, sleep_count});
        end
        rst = 1'b0;
        step();
        n_vec++;
        if ({sleep_req, clk_gate, pwr_state, ack_timeout_err, sleep_count} !== 52'd0) begin
            n_err++; $display("FAIL post_reset_outputs got=%h exp=0", {sleep_req, clk_gate, pwr_state, ack_timeout_err, sleep_count});
        end
        periph_en = 4'hF; idle_threshold = 16'd10;
    endtask

    task automatic test_sleep_entry();
        for (int v = 0; v <= 10; v++) begin
            idle_count[15:0] = 16'(v);
            step();
            n_vec++;
            if (pwr_state[1:0] !== ((v == 10) ? 2'd1 : 2'd0) || sleep_req !== ((v == 10) ? 4'b0001 : 4'b0000)) begin
                n_err++; $display("FAIL ramp_%0d got state=%0d req=%b", v, pwr_state[1:0], sleep_req);
            end
        end
        sleep_ack[0] = 1'b1; idle_count[15:0] = 16'd0;
        step();
        sleep_ack[0] = 1'b0;
        n_vec++;
        if (pwr_state[1:0] !== 2'd2 || clk_gate !== 4'b0001 || sleep_req !== 4'b0000) begin
            n_err++; $display("FAIL ack_to_sleep got state=%0d gate=%b req=%b exp 2/0001/0000", pwr_state[1:0], clk_gate, sleep_req);
        end
        wake_req[0] = 1'b1;
        step();
        wake_req[0] = 1'b0;
        for (int k = 0; k < 4; k++) step();
        n_vec++;
        if (pwr_state[1:0] !== 2'd0) begin
            n_err++; $display("FAIL sleep_exit got=%0d exp=0", pwr_state[1:0]);
        end
    endtask

    task automatic test_timeout();
        idle_count[15:0] = 16'd10;
        step();
        idle_count[15:0] = 16'd0;
        n_vec++;
        if (pwr_state[1:0] !== 2'd1) begin
            n_err++; $display("FAIL to_entry got=%0d exp=1", pwr_state[1:0]);
        end
        for (int k = 1; k < 16; k++) begin
            step();
            n_vec++;
            if (pwr_state[1:0] !== 2'd1 || ack_timeout_err !== 4'b0000) begin
                n_err++; $display("FAIL to_wait_%0d got state=%0d err=%b exp 1/0000", k, pwr_state[1:0], ack_timeout_err);
            end
        end
        step();
        n_vec++;
        if (pwr_state[1:0] !== 2'd0 || ack_timeout_err !== 4'b0001 || sleep_req !== 4'b0000) begin
            n_err++; $display("FAIL to_fire got state=%0d err=%b req=%b exp 0/0001/0000", pwr_state[1:0], ack_timeout_err, sleep_req);
        end
        step();
        n_vec++;
        if (ack_timeout_err !== 4'b0000) begin
            n_err++; $display("FAIL to_pulse_end got=%b exp=0000", ack_timeout_err);
        end
    endtask

    task automatic test_wake();
        idle_count[31:16] = 16'd10;
        step();
        sleep_ack[1] = 1'b1; idle_count[31:16] = 16'd0;
        step();
        sleep_ack[1] = 1'b0;
        wake_req[1] = 1'b1;
        step();
        wake_req[1] = 1'b0;
        n_vec++;
        if (pwr_state[3:2] !== 2'd3 || clk_gate !== 4'b0000) begin
            n_err++; $display("FAIL wake_enter got state=%0d gate=%b exp 3/0000", pwr_state[3:2], clk_gate);
        end
        for (int k = 1; k < 4; k++) begin
            wake_req[1] = (k == 2);
            step();
            n_vec++;
            if (pwr_state[3:2] !== 2'd3) begin
                n_err++; $display("FAIL wake_hold_%0d got=%0d exp=3", k, pwr_state[3:2]);
            end
        end
        wake_req[1] = 1'b0;
        step();
        n_vec++;
        if (pwr_state[3:2] !== 2'd0) begin
            n_err++; $display("FAIL wake_done got=%0d exp=0", pwr_state[3:2]);
        end
    endtask

    task automatic test_priority();
        idle_count[47:32] = 16'd10;
        step();
        idle_count[47:32] = 16'd0;
        sleep_ack[2] = 1'b1; recent_activity[2] = 1'b1;
        step();
        sleep_ack[2] = 1'b0; recent_activity[2] = 1'b0;
        n_vec++;
        if (pwr_state[5:4] !== 2'd2 || clk_gate !== 4'b0100) begin
            n_err++; $display("FAIL ack_over_abort got state=%0d gate=%b exp 2/0100", pwr_state[5:4], clk_gate);
        end
        periph_en[2] = 1'b0;
        step();
        periph_en[2] = 1'b1;
        n_vec++;
        if (pwr_state[5:4] !== 2'd0 || clk_gate !== 4'b0000) begin
            n_err++; $display("FAIL disable_in_sleep got state=%0d gate=%b exp 0/0000", pwr_state[5:4], clk_gate);
        end
        idle_count[63:48] = 16'd12; recent_activity[3] = 1'b1;
        step();
        n_vec++;
        if (pwr_state[7:6] !== 2'd0) begin
            n_err++; $display("FAIL activity_blocks got=%0d exp=0", pwr_state[7:6]);
        end
        recent_activity[3] = 1'b0;
        step();
        idle_count[63:48] = 16'd0; recent_activity[3] = 1'b1;
        step();
        recent_activity[3] = 1'b0;
        n_vec++;
        if (pwr_state[7:6] !== 2'd0 || sleep_req !== 4'b0000 || ack_timeout_err !== 4'b0000) begin
            n_err++; $display("FAIL abort got state=%0d req=%b err=%b exp 0/0000/0000", pwr_state[7:6], sleep_req, ack_timeout_err);
        end
    endtask

    task automatic test_threshold_zero_and_reset();
        idle_threshold = 16'd0; idle_count = {4{16'hFFFF}};
        for (int k = 0; k < 20; k++) begin
            step();
            n_vec++;
            if (pwr_state !== 8'd0 || sleep_req !== 4'd0) begin
                n_err++; $display("FAIL thr_zero_%0d got state=%h req=%b exp 00/0000", k, pwr_state, sleep_req);
            end
        end
        idle_threshold = 16'd10; idle_count = 64'd0; idle_count[15:0] = 16'hFFFF;
        step();
        sleep_ack[0] = 1'b1; idle_count[15:0] = 16'd0;
        step();
        sleep_ack[0] = 1'b0;
        n_vec++;
        if (clk_gate !== 4'b0001) begin
            n_err++; $display("FAIL pre_rst_sleep got=%b exp=0001", clk_gate);
        end
        rst = 1'b1;
        step();
        n_vec++;
        if ({sleep_req, clk_gate, pwr_state, ack_timeout_err, sleep_count} !== 52'd0) begin
            n_err++; $display("FAIL rst_in_sleep got=%h exp=0", {sleep_req, clk_gate, pwr_state, ack_timeout_err, sleep_count});
        end
        rst = 1'b0;
        step();
        n_vec++;
        if ({sleep_req, clk_gate, pwr_state, ack_timeout_err} !== 20'd0) begin
            n_err++; $display("FAIL after_rst got=%h exp=0", {sleep_req, clk_gate, pwr_state, ack_timeout_err});
        end
    endtask

    task automatic test_stats();
        logic [7:0] exp_cnt;
        exp_cnt = 8'd0;
        for (int e = 1; e <= 300; e++) begin
            idle_count[47:32] = 16'd10;
            step();
            idle_count[47:32] = 16'd0; sleep_ack[2] = 1'b1;
            step();
            sleep_ack[2] = 1'b0; periph_en[2] = 1'b0;
            step();
            periph_en[2] = 1'b1;
`ifdef IDLE_PWR_STATS_EN
            exp_cnt = (e > 255) ? 8'd255 : 8'(e);
`endif
            if (e == 10 || e == 255 || e == 300) begin
                n_vec++;
                if (sleep_count !== {8'd0, exp_cnt, 16'd0}) begin
                    n_err++; $display("FAIL stats_%0d got=%h exp=%h", e, sleep_count, {8'd0, exp_cnt, 16'd0});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_sleep_entry();
        test_timeout();
        test_wake();
        test_priority();
        test_threshold_zero_and_reset();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
